// File: rtl/bram_fifo_cfg.sv
// rtl/bram_fifo_cfg.sv - configurable BlockRAM tile: byte-lane RAM or FIFO with optional output register
module bram_fifo_cfg #(
  parameter int  DATA_WIDTH = 32,
  parameter int  ADDR_WIDTH = 8,
  localparam int LANES      = DATA_WIDTH / 8,
  localparam int SEL_W      = $clog2(LANES)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cfg_mode,
  input  logic [1:0]                  cfg_wr_width,
  input  logic [1:0]                  cfg_rd_width,
  input  logic                        cfg_out_reg,
  input  logic                        wr_en,
  input  logic [ADDR_WIDTH+SEL_W-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]       wr_data,
  input  logic                        rd_en,
  input  logic [ADDR_WIDTH+SEL_W-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]       rd_data,
  output logic                        rd_valid,
  output logic                        full,
  output logic                        empty,
  output logic [ADDR_WIDTH:0]         count,
  output logic                        overflow,
  output logic                        underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int AW    = ADDR_WIDTH + SEL_W;
  localparam int HALF  = DATA_WIDTH / 2;
  localparam logic [1:0] W_HALF = 2'd1;
  localparam logic [1:0] W_BYTE = 2'd2;
  localparam logic [LANES-1:0]    LO_MASK   = {{(LANES/2){1'b0}}, {(LANES/2){1'b1}}};
  localparam logic [ADDR_WIDTH:0] COUNT_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  full_q, full_d, empty_q, empty_d;
  logic                  ovf_q, ovf_d, udf_q, udf_d;
  logic                  push, pop;

  logic [ADDR_WIDTH-1:0] waddr, raddr;
  logic [LANES-1:0]      wmask;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  mem_re;
  logic [SEL_W-1:0]      rsel;
  logic [1:0]            rwid;

  logic [DATA_WIDTH-1:0] rword_q;
  logic [SEL_W-1:0]      rsel_q;
  logic [1:0]            rwid_q;
  logic                  v1_q, v2_q;
  logic [DATA_WIDTH-1:0] rd_aligned, dout_q;

  // FIFO bookkeeping; a pop frees a slot so a push into a full FIFO is legal on the same edge
  always_comb begin
    pop      = cfg_mode & rd_en & ~empty_q;
    push     = cfg_mode & wr_en & (~full_q | pop);
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    full_d  = cfg_mode & (count_d == COUNT_MAX);
    empty_d = cfg_mode & (count_d == '0);
    ovf_d   = ovf_q | (cfg_mode & wr_en & ~push);
    udf_d   = udf_q | (cfg_mode & rd_en & ~pop);
  end

  // Narrow writes replicate the LSBs across the word so the byte mask alone picks the lanes
  always_comb begin
    wmask = '0;
    wdata = wr_data;
    waddr = wr_addr[AW-1:SEL_W];
    if (cfg_mode) begin
      waddr = wr_ptr_q;
      wmask = {LANES{push}};
    end else if (wr_en) begin
      case (cfg_wr_width)
        W_HALF: begin
          wmask = wr_addr[SEL_W-1] ? ~LO_MASK : LO_MASK;
          wdata = {2{wr_data[HALF-1:0]}};
        end
        W_BYTE: begin
          wmask[wr_addr[SEL_W-1:0]] = 1'b1;
          wdata = {LANES{wr_data[7:0]}};
        end
        default: wmask = '1;
      endcase
    end
  end

  always_comb begin
    raddr  = rd_addr[AW-1:SEL_W];
    mem_re = rd_en;
    rsel   = rd_addr[SEL_W-1:0];
    rwid   = cfg_rd_width;
    if (cfg_mode) begin
      raddr  = rd_ptr_q;
      mem_re = pop;
      rsel   = '0;
      rwid   = '0;
    end
  end

  always_comb begin
    rd_aligned = rword_q;
    case (rwid_q)
      W_HALF:  rd_aligned = rsel_q[SEL_W-1] ? {{HALF{1'b0}}, rword_q[DATA_WIDTH-1:HALF]}
                                             : {{HALF{1'b0}}, rword_q[HALF-1:0]};
      W_BYTE:  rd_aligned = {{(DATA_WIDTH-8){1'b0}}, rword_q[{rsel_q, 3'b000} +: 8]};
      default: rd_aligned = rword_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int l = 0; l < LANES; l++) begin
        if (wmask[l]) mem_q[waddr][l*8 +: 8] <= wdata[l*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= cfg_mode;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      rword_q  <= '0;
      rsel_q   <= '0;
      rwid_q   <= '0;
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      // Nonblocking read of mem_q gives read-first behaviour on a same-word collision
      if (mem_re) begin
        rword_q <= mem_q[raddr];
        rsel_q  <= rsel;
        rwid_q  <= rwid;
      end
      v1_q <= mem_re;
      v2_q <= v1_q;
      if (v1_q) dout_q <= rd_aligned;
    end
  end

  assign rd_data   = cfg_out_reg ? dout_q : rd_aligned;
  assign rd_valid  = cfg_out_reg ? v2_q : v1_q;
  assign full      = full_q;
  assign empty     = empty_q;
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign underflow = udf_q;

endmodule

// File: tb/tb_bram_fifo_cfg.sv
// tb/tb_bram_fifo_cfg.sv - directed and randomized bench for bram_fifo_cfg against a byte-array / queue model
module tb_bram_fifo_cfg;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_mode;
  logic [1:0]  cfg_wr_width, cfg_rd_width;
  logic        cfg_out_reg;
  logic        wr_en, rd_en;
  logic [5:0]  wr_addr, rd_addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        rd_valid, full, empty, overflow, underflow;
  logic [4:0]  count;

  int n_cmp = 0;
  int n_err = 0;

  bram_fifo_cfg #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .cfg_wr_width(cfg_wr_width),
    .cfg_rd_width(cfg_rd_width), .cfg_out_reg(cfg_out_reg), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  logic [7:0]  ram_m [16][4];
  logic [31:0] fq[$];
  logic        m_ovf, m_udf;
  logic        pv1, pv2;
  logic [31:0] pd1, pd2, hold;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_read(input int w, input int sel, input logic [1:0] wid);
    case (wid)
      2'd1:    return (sel >= 2) ? {16'h0, ram_m[w][3], ram_m[w][2]} : {16'h0, ram_m[w][1], ram_m[w][0]};
      2'd2:    return {24'h0, ram_m[w][sel]};
      default: return {ram_m[w][3], ram_m[w][2], ram_m[w][1], ram_m[w][0]};
    endcase
  endfunction

  task automatic model_write(input int w, input int sel, input logic [1:0] wid, input logic [31:0] d);
    int base;
    case (wid)
      2'd1: begin
        base = (sel >= 2) ? 2 : 0;
        ram_m[w][base]   = d[7:0];
        ram_m[w][base+1] = d[15:8];
      end
      2'd2: ram_m[w][sel] = d[7:0];
      default: for (int b = 0; b < 4; b++) ram_m[w][b] = d[b*8 +: 8];
    endcase
  endtask

  task automatic check_all(input logic exp_v);
    int sz;
    sz = fq.size();
    chk("rd_valid", {31'b0, rd_valid}, {31'b0, exp_v});
    chk("rd_data", rd_data, hold);
    chk("count", {27'b0, count}, sz);
    chk("full", {31'b0, full}, {31'b0, cfg_mode && sz == 16});
    chk("empty", {31'b0, empty}, {31'b0, cfg_mode && sz == 0});
    chk("overflow", {31'b0, overflow}, {31'b0, m_ovf});
    chk("underflow", {31'b0, underflow}, {31'b0, m_udf});
  endtask

  task automatic step();
    logic acc, pop_ok, push_ok, exp_v;
    logic [31:0] word;
    acc = 1'b0;
    word = '0;
    if (cfg_mode) begin
      pop_ok  = rd_en && fq.size() > 0;
      push_ok = wr_en && (fq.size() < 16 || pop_ok);
      if (pop_ok) begin
        acc = 1'b1;
        word = fq.pop_front();
      end else if (rd_en) m_udf = 1'b1;
      if (push_ok) fq.push_back(wr_data);
      else if (wr_en) m_ovf = 1'b1;
    end else begin
      if (rd_en) begin
        acc = 1'b1;
        word = model_read(int'(rd_addr[5:2]), int'(rd_addr[1:0]), cfg_rd_width);
      end
      if (wr_en) model_write(int'(wr_addr[5:2]), int'(wr_addr[1:0]), cfg_wr_width, wr_data);
    end
    pv2 = pv1;
    pd2 = pd1;
    pv1 = acc;
    if (acc) pd1 = word;
    tick();
    exp_v = cfg_out_reg ? pv2 : pv1;
    if (exp_v) hold = cfg_out_reg ? pd2 : pd1;
    check_all(exp_v);
  endtask

  task automatic drive(input logic we, input logic [5:0] wa, input logic [31:0] wd,
                       input logic re, input logic [5:0] ra);
    wr_en = we; wr_addr = wa; wr_data = wd; rd_en = re; rd_addr = ra;
  endtask

  task automatic idle();
    drive(1'b0, 6'd0, 32'd0, 1'b0, 6'd0);
    step();
  endtask

  task automatic do_reset(input logic mode, input logic oreg);
    rst = 1'b1; cfg_mode = mode; cfg_out_reg = oreg;
    wr_en = 1'b0; rd_en = 1'b0;
    fq.delete();
    m_ovf = 1'b0; m_udf = 1'b0;
    pv1 = 1'b0; pv2 = 1'b0; hold = '0;
    repeat (2) begin
      tick();
      check_all(1'b0);
    end
    rst = 1'b0;
  endtask

  initial begin
    cfg_wr_width = 2'd0; cfg_rd_width = 2'd0;
    wr_addr = '0; wr_data = '0; rd_addr = '0;
    pd1 = '0; pd2 = '0;
    do_reset(1'b0, 1'b0);

    for (int w = 0; w < 16; w++) begin
      drive(1'b1, {w[3:0], 2'b00}, $urandom, 1'b0, 6'd0);
      step();
    end

    // byte-lane writes to word 5, then full read at N+1
    cfg_wr_width = 2'd2;
    for (int s = 0; s < 4; s++) begin
      drive(1'b1, {4'd5, s[1:0]}, 32'hAA + 32'h11 * s, 1'b0, 6'd0);
      step();
    end
    cfg_rd_width = 2'd0;
    drive(1'b0, 6'd0, 32'd0, 1'b1, {4'd5, 2'b00});
    step();
    chk("tp_byte_word5_n1", rd_data, 32'hDDCCBBAA);
    idle();

    do_reset(1'b0, 1'b1);
    drive(1'b0, 6'd0, 32'd0, 1'b1, {4'd5, 2'b00});
    step();
    idle();
    chk("tp_byte_word5_n2", rd_data, 32'hDDCCBBAA);
    idle();

    cfg_rd_width = 2'd1;
    drive(1'b0, 6'd0, 32'd0, 1'b1, {4'd5, 2'b10});
    step();
    idle();
    chk("tp_half_upper", rd_data, 32'h0000DDCC);

    do_reset(1'b0, 1'b0);
    cfg_wr_width = 2'd0; cfg_rd_width = 2'd0;
    drive(1'b1, {4'd3, 2'b00}, 32'h11111111, 1'b0, 6'd0);
    step();
    drive(1'b1, {4'd3, 2'b00}, 32'h22222222, 1'b1, {4'd3, 2'b00});
    step();
    chk("tp_collision_old", rd_data, 32'h11111111);
    drive(1'b0, 6'd0, 32'd0, 1'b1, {4'd3, 2'b00});
    step();
    chk("tp_collision_new", rd_data, 32'h22222222);

    for (int ph = 0; ph < 2; ph++) begin
      do_reset(1'b0, ph[0]);
      for (int i = 0; i < 150; i++) begin
        cfg_wr_width = 2'($urandom_range(0, 3));
        cfg_rd_width = 2'($urandom_range(0, 3));
        drive(1'($urandom_range(0, 1)), 6'($urandom), $urandom, 1'($urandom_range(0, 1)), 6'($urandom));
        if ($urandom_range(0, 3) == 0) rd_addr = wr_addr;
        step();
      end
    end

    // reset lands while a registered read is in flight
    do_reset(1'b0, 1'b1);
    cfg_wr_width = 2'd0; cfg_rd_width = 2'd0;
    drive(1'b1, {4'd7, 2'b00}, 32'hCAFEF00D, 1'b0, 6'd0);
    step();
    drive(1'b0, 6'd0, 32'd0, 1'b1, {4'd7, 2'b00});
    step();
    do_reset(1'b0, 1'b1);
    repeat (3) idle();
    drive(1'b0, 6'd0, 32'd0, 1'b1, {4'd7, 2'b00});
    step();
    idle();
    chk("tp_ram_intact", rd_data, 32'hCAFEF00D);
    do_reset(1'b1, 1'b1);
    chk("tp_rst_fifo_empty", {31'b0, empty}, 32'd1);

    // FIFO fill, full push+pop, overflow, drain, underflow
    do_reset(1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 6'd0, i, 1'b0, 6'd0);
      step();
    end
    chk("tp_fifo_full", {31'b0, full}, 32'd1);
    chk("tp_fifo_count16", {27'b0, count}, 32'd16);
    drive(1'b1, 6'd0, 32'h99, 1'b1, 6'd0);
    step();
    chk("tp_full_pushpop_data", rd_data, 32'd0);
    chk("tp_full_pushpop_count", {27'b0, count}, 32'd16);
    chk("tp_full_pushpop_ovf", {31'b0, overflow}, 32'd0);
    drive(1'b1, 6'd0, 32'hDEAD, 1'b0, 6'd0);
    step();
    chk("tp_overflow", {31'b0, overflow}, 32'd1);
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 6'd0, 32'd0, 1'b1, 6'd0);
      step();
      if (i == 0) chk("tp_first_pop", rd_data, 32'd1);
    end
    chk("tp_fifo_empty", {31'b0, empty}, 32'd1);
    step();
    chk("tp_underflow", {31'b0, underflow}, 32'd1);
    chk("tp_underflow_novalid", {31'b0, rd_valid}, 32'd0);

    do_reset(1'b1, 1'b0);
    drive(1'b1, 6'd0, 32'h5A5A, 1'b1, 6'd0);
    step();
    chk("tp_empty_pushpop_count", {27'b0, count}, 32'd1);
    chk("tp_empty_pushpop_udf", {31'b0, underflow}, 32'd1);

    for (int ph = 0; ph < 2; ph++) begin
      do_reset(1'b1, ph[0]);
      for (int i = 0; i < 300; i++) begin
        int pct;
        pct = ((i / 50) % 2 == 0) ? 80 : 25;
        drive($urandom_range(0, 99) < pct, 6'($urandom), $urandom,
              $urandom_range(0, 99) < (100 - pct), 6'($urandom));
        step();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bram_fifo_cfg.md
Name: bram_fifo_cfg

Overview:
- Next-generation fabric BlockRAM tile.
- Behavioural dual-port memory, parametrised in word width and depth.
- Two modes, selected by a static configuration input:
  - RAM mode: independent read/write ports with per-port width modes (full/half/byte).
  - FIFO mode: internal pointers, occupancy count, full/empty and sticky error flags.
- Optional output register and a read-valid strobe on the read path.

Parameters:
- DATA_WIDTH, 32, word width in bits; legal values 32 or 64.
- ADDR_WIDTH, 8, word address width; depth = 2^ADDR_WIDTH words.
- LANES, DATA_WIDTH/8, byte lanes per word (derived, not overridable).
- SEL_W, log2(LANES), sub-word select bits (derived).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_mode  in  1  0 = RAM, 1 = FIFO; static, changed only while rst is high.
- cfg_wr_width  in  2  0 = full, 1 = half, 2 = byte, 3 = reserved (treated as full); RAM mode only.
- cfg_rd_width  in  2  same encoding as cfg_wr_width, for the read port.
- cfg_out_reg  in  1  1 = extra output register (adds 1 cycle of latency).
- wr_en  in  1  write (RAM) / push (FIFO) request.
- wr_addr  in  ADDR_WIDTH+SEL_W  {word, sub-word}; ignored in FIFO mode.
- wr_data  in  DATA_WIDTH  narrow writes take data from the LSBs.
- rd_en  in  1  read (RAM) / pop (FIFO) request.
- rd_addr  in  ADDR_WIDTH+SEL_W  {word, sub-word}; ignored in FIFO mode.
- rd_data  out  DATA_WIDTH  read data; narrow reads are right-aligned and zero-extended.
- rd_valid  out  1  one-cycle strobe, aligned with rd_data.
- full  out  1  FIFO full; 0 in RAM mode.
- empty  out  1  FIFO empty; 0 in RAM mode.
- count  out  ADDR_WIDTH+1  FIFO occupancy; 0 in RAM mode.
- overflow  out  1  sticky: a push was refused.
- underflow  out  1  sticky: a pop was refused.

Behaviour:
- Reset values:
  - rd_data = 0, rd_valid = 0, full = 0, overflow = 0, underflow = 0, count = 0.
  - empty = cfg_mode.
  - Pointers and the output register are cleared.
- Memory contents are not reset.
- A reset during an in-flight read cancels it: no rd_valid is produced after rst is asserted.

RAM write path:
- Byte mask derived from cfg_wr_width and the sub-word select.
- full: all lanes.
- half: lower or upper LANES/2 lanes, selected by the sub-word MSB.
- byte: the single lane selected by the full sub-word field.
- Unselected sub-word bits are ignored.
- Write commits at the rising edge where wr_en = 1.

RAM read path:
- Word fetched at the edge where rd_en = 1.
- Lane select is captured and pipelined alongside the data.
- Latency: rd_en at cycle N gives rd_data/rd_valid at N+1 (cfg_out_reg = 0) or N+2 (cfg_out_reg = 1).
- rd_data holds its value between strobes.
- Collision (same word address, same edge): read-first; the read returns the old contents.

FIFO mode:
- Full DATA_WIDTH words; cfg widths are ignored.
- Pointers wr_ptr and rd_ptr, ADDR_WIDTH bits each; wrap 2^ADDR_WIDTH-1 -> 0.
- Push accepted iff wr_en && (!full || pop accepted this cycle).
- Pop accepted iff rd_en && !empty.
- Full with simultaneous push and pop: both accepted, count unchanged; the pop returns the oldest word (read-first).
- Empty with simultaneous push and pop: push accepted, pop refused, underflow set.
- Refused push sets overflow; the write is dropped and memory is unchanged.
- count: +1 on push only, -1 on pop only, unchanged otherwise.
- full = (count == 2^ADDR_WIDTH); empty = (count == 0). Both are registered and update the cycle after the causing edge.
- Pop latency and rd_valid timing are identical to a RAM read.
- overflow and underflow clear only on rst.

Test Plan:
- RAM byte lanes (DATA_WIDTH = 32, cfg_wr_width = 2): write 0xAA, 0xBB, 0xCC, 0xDD to word 5, sub-words 0..3; full-width read of word 5 -> 0xDDCCBBAA, rd_valid at N+1; same read with cfg_out_reg = 1 -> N+2.
- RAM half read (cfg_rd_width = 1): word 5 = 0xDDCCBBAA, read sub-word MSB = 1 -> rd_data = 0x0000DDCC.
- RAM collision: word 3 = 0x11111111; on the same edge write 0x22222222 to word 3 and read word 3 -> read returns 0x11111111; next read -> 0x22222222.
- FIFO fill/drain (ADDR_WIDTH = 4): 16 pushes of 0..15 -> full = 1, count = 16; 17th push -> overflow = 1, contents unchanged; 16 pops -> 0..15 in order, empty = 1; extra pop -> underflow = 1, no rd_valid.
- FIFO boundaries: when full, simultaneous push 0x99 and pop -> returns the oldest word, count stays 16, overflow stays 0; when empty, simultaneous push and pop -> count = 1, underflow = 1.
- Reset mid-read: rd_en at N, rst at N+1 (cfg_out_reg = 1) -> rd_valid never asserts; after reset count = 0 and empty = 1 in FIFO mode; RAM contents written before reset read back intact.
